// File: rtl/sync_pkg.sv
// sync_pkg: shared constants and helpers for the sync_filt_edge synchroniser family.
`default_nettype none

package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // A counter of zero width is illegal, so one bit is the floor even when FILTER is 1.
  function automatic int cnt_width(input int filter);
    return (clog2(filter) < 1) ? 1 : clog2(filter);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_filt_chan.sv
// sync_filt_chan: one channel of sync_filt_edge (flop chain, stability filter,
// edge detect and sticky event bit).
`default_nettype none

module sync_filt_chan
  import sync_pkg::*;
#(
  parameter int   STAGES = 2,
  parameter int   FILTER = 0,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset_,
  input  logic sync_in,
  input  logic event_clr,
  output logic sync_out,
  output logic rise,
  output logic fall,
  output logic event_sticky
);

  logic [STAGES-1:0] chain;
  logic              s;
  logic              level;
  logic              level_d;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      chain <= {STAGES{INIT}};
    end else begin
      chain <= {chain[STAGES-2:0], sync_in};
    end
  end

  assign s = chain[STAGES-1];

  if (FILTER == 0) begin : g_nofilt
    assign level = s;
  end else begin : g_filt
    localparam int            CW       = cnt_width(FILTER);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [CW-1:0] cnt;
    logic          filt;

    // Counter only advances while s disagrees with the accepted level, so a
    // short excursion leaves it back at zero as soon as s returns.
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        cnt  <= '0;
        filt <= INIT;
      end else if (s == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign level = filt;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      level_d      <= INIT;
      event_sticky <= 1'b0;
    end else begin
      level_d      <= level;
      // An edge in the same cycle as a clear wins, so no event is lost.
      event_sticky <= (event_sticky & ~event_clr) | rise | fall;
    end
  end

  assign sync_out = level;
  assign rise     = level & ~level_d;
  assign fall     = ~level & level_d;

endmodule

`default_nettype wire

// File: rtl/sync_filt_edge.sv
// sync_filt_edge: WIDTH independent asynchronous inputs synchronised into clk,
// optionally debounced, with edge pulses and sticky event flags.
`default_nettype none

module sync_filt_edge
  import sync_pkg::*;
#(
  parameter int               WIDTH  = 1,
  parameter int               STAGES = 2,
  parameter int               FILTER = 0,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] event_sticky,
  input  logic [WIDTH-1:0] event_clr
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_stages_bad
    $error("sync_filt_edge: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN,
           SYNC_STAGES_MAX);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filt_chan #(
      .STAGES (STAGES),
      .FILTER (FILTER),
      .INIT   (INIT[i])
    ) u_chan (
      .clk          (clk),
      .reset_       (reset_),
      .sync_in      (sync_in[i]),
      .event_clr    (event_clr[i]),
      .sync_out     (sync_out[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .event_sticky (event_sticky[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_filt_edge.sv
// tb_sync_filt_edge: directed checks of sync_filt_edge across several parameter sets.
`default_nettype none

module tb_sync_filt_edge;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // A: WIDTH=1 STAGES=2 FILTER=0 INIT=0
  logic a_in = 1'b0, a_clr = 1'b0, a_out, a_rise, a_fall, a_st;
  // B: WIDTH=1 STAGES=3 FILTER=4 INIT=0
  logic b_in = 1'b0, b_clr = 1'b0, b_out, b_rise, b_fall, b_st;
  // C: WIDTH=1 STAGES=2 FILTER=2 INIT=1
  logic c_in = 1'b1, c_clr = 1'b0, c_out, c_rise, c_fall, c_st;
  // D: WIDTH=4 STAGES=2 FILTER=0 INIT=0
  logic [3:0] d_in = '0, d_clr = '0, d_out, d_rise, d_fall, d_st;
  // E: WIDTH=1 STAGES=2 FILTER=8 INIT=0
  logic e_in = 1'b0, e_clr = 1'b0, e_out, e_rise, e_fall, e_st;

  sync_filt_edge #(.WIDTH(1), .STAGES(2), .FILTER(0), .INIT(1'b0)) dut_a (
    .clk(clk), .reset_(reset_), .sync_in(a_in), .sync_out(a_out), .rise(a_rise),
    .fall(a_fall), .event_sticky(a_st), .event_clr(a_clr));

  sync_filt_edge #(.WIDTH(1), .STAGES(3), .FILTER(4), .INIT(1'b0)) dut_b (
    .clk(clk), .reset_(reset_), .sync_in(b_in), .sync_out(b_out), .rise(b_rise),
    .fall(b_fall), .event_sticky(b_st), .event_clr(b_clr));

  sync_filt_edge #(.WIDTH(1), .STAGES(2), .FILTER(2), .INIT(1'b1)) dut_c (
    .clk(clk), .reset_(reset_), .sync_in(c_in), .sync_out(c_out), .rise(c_rise),
    .fall(c_fall), .event_sticky(c_st), .event_clr(c_clr));

  sync_filt_edge #(.WIDTH(4), .STAGES(2), .FILTER(0), .INIT(4'b0000)) dut_d (
    .clk(clk), .reset_(reset_), .sync_in(d_in), .sync_out(d_out), .rise(d_rise),
    .fall(d_fall), .event_sticky(d_st), .event_clr(d_clr));

  sync_filt_edge #(.WIDTH(1), .STAGES(2), .FILTER(8), .INIT(1'b0)) dut_e (
    .clk(clk), .reset_(reset_), .sync_in(e_in), .sync_out(e_out), .rise(e_rise),
    .fall(e_fall), .event_sticky(e_st), .event_clr(e_clr));

  typedef struct {
    logic [3:0] in;
    logic [3:0] clr;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] sticky;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset_ = 1'b0;
    step();
    step();
  endtask

  initial begin
    // Values observed after each edge; ch2 toggles, then edge+clear collide at step 4.
    //            in       clr      out      rise     fall     sticky
    tbl[0] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    tbl[4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    tbl[5] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    tbl[8] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
    tbl[9] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100};

    // Reset state
    hold_reset();
    check("rst_a_out", a_out, 0);
    check("rst_a_pulse", {a_rise, a_fall, a_st}, 0);
    check("rst_c_out_init", c_out, 1);
    check("rst_c_pulse", {c_rise, c_fall, c_st}, 0);
    check("rst_d_out", d_out, 0);
    reset_ = 1'b1;
    step();
    check("rel_c_out", c_out, 1);
    check("rel_c_no_edge", {c_rise, c_fall}, 0);
    check("rel_a_out", a_out, 0);

    // A: two-stage latency, single rise pulse, sticky set afterwards
    a_in = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      check($sformatf("a_out_%0d", j), a_out, (j >= 2) ? 1 : 0);
      check($sformatf("a_rise_%0d", j), a_rise, (j == 2) ? 1 : 0);
      check($sformatf("a_st_%0d", j), a_st, (j >= 3) ? 1 : 0);
      check($sformatf("c_quiet_%0d", j), {c_out, c_rise, c_fall}, 3'b100);
    end

    // C: INIT=1 filtered channel falls after STAGES+FILTER edges
    c_in = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      check($sformatf("c_out_%0d", j), c_out, (j < 4) ? 1 : 0);
      check($sformatf("c_fall_%0d", j), c_fall, (j == 4) ? 1 : 0);
      check($sformatf("c_rise_%0d", j), c_rise, 0);
    end

    // D: table-driven channel isolation and sticky/clear interaction
    for (int i = 0; i < 10; i++) begin
      d_in  = tbl[i].in;
      d_clr = tbl[i].clr;
      step();
      check($sformatf("d_out_%0d", i), d_out, tbl[i].out);
      check($sformatf("d_rise_%0d", i), d_rise, tbl[i].rise);
      check($sformatf("d_fall_%0d", i), d_fall, tbl[i].fall);
      check($sformatf("d_sticky_%0d", i), d_st, tbl[i].sticky);
    end
    d_clr = '0;

    // B: a 3-cycle glitch is rejected, then a held level needs the full 7 edges
    hold_reset();
    reset_ = 1'b1;
    b_in = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step();
      check($sformatf("b_glitch_out_%0d", j), b_out, 0);
    end
    b_in = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("b_glitch_hold_%0d", j), {b_out, b_rise, b_st}, 0);
    end
    b_in = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      check($sformatf("b_out_%0d", j), b_out, (j >= 7) ? 1 : 0);
      check($sformatf("b_rise_%0d", j), b_rise, (j == 7) ? 1 : 0);
    end

    // E: asynchronous reset mid-count discards the partial count
    hold_reset();
    reset_ = 1'b1;
    e_in = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      step();
      check($sformatf("e_pre_out_%0d", j), e_out, 0);
    end
    #2;
    reset_ = 1'b0;
    #1;
    check("async_e", {e_out, e_rise, e_fall, e_st}, 0);
    check("async_a_out", a_out, 0);
    check("async_b_out", b_out, 0);
    check("async_c_out_init", c_out, 1);
    check("async_d_sticky", d_st, 0);
    step();
    reset_ = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      step();
      check($sformatf("e_out_%0d", j), e_out, (j >= 10) ? 1 : 0);
      check($sformatf("e_rise_%0d", j), e_rise, (j == 10) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
